fifo_rd_scheduler: RTL and testbench
====================================

Name: fifo_rd_scheduler

Overview:
Read-side scheduler that drains N_CH dual-clock FIFOs into one output stream, entirely in the clk_rd domain. Per channel it sees the FIFO's buf_empty flag and registered buf_out byte, and drives that FIFO's rd_en. Channels are granted round-robin with a bounded burst length per grant. The output is a valid/ready stream tagged with the source channel number.

Parameters:
N_CH, 4, number of FIFO channels (2..8)
DW, 8, data width per channel
BURST_MAX, 4, max consecutive reads per grant (1..15)
CHW, 2, channel index width, clog2(N_CH)

Ports:
clk_rd      in   1         read-domain clock shared with all FIFO read sides
rst         in   1         asynchronous, active-high reset
ch_empty    in   N_CH      per-FIFO buf_empty, bit i = channel i
ch_data     in   N_CH*DW   per-FIFO buf_out, channel i at [i*DW +: DW]
ch_enable   in   N_CH      channel mask; 0 = never granted
ch_rd_en    out  N_CH      per-FIFO rd_en, one-hot or zero
out_data    out  DW        output word
out_ch      out  CHW       source channel of out_data
out_valid   out  1         output word valid
out_ready   in   1         downstream accepts word when out_valid & out_ready
busy        out  1         1 while state is BURST or a read is in flight
word_count  out  16        total words delivered (handshakes), wraps at 65535->0

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_data=0, out_ch=0, word_count=0, ch_rd_en=0.
  - state=IDLE, rr_ptr=0, grant=0, burst_cnt=0, rd_pend=0.
  - Any in-flight read is discarded.
- can_issue = !rd_pend_next_blocked, i.e. (!out_valid | out_ready) & !(rd_pend & out_valid & !out_ready). Only one unaccepted word is held; no skid buffer.
- State IDLE:
  - eligible = ch_enable & ~ch_empty.
  - If eligible != 0: grant = first eligible index searching rr_ptr, rr_ptr+1, ... mod N_CH; burst_cnt=0; go to BURST.
  - No rd_en in the IDLE cycle, so arbitration costs 1 cycle.
- State BURST:
  - ch_rd_en[grant] = can_issue & !ch_empty[grant] & ch_enable[grant]; all other bits are 0.
  - On issue: burst_cnt++, rd_pend<=1, rd_ch<=grant.
  - Exit to IDLE with rr_ptr<=(grant+1) mod N_CH when any of these holds:
    - the issue makes burst_cnt==BURST_MAX;
    - ch_empty[grant]=1 or ch_enable[grant]=0 in a cycle where can_issue=1.
  - Otherwise stay in BURST (stalled while !can_issue).
- Read latency:
  - FIFO buf_out is registered, so data appears the cycle after rd_en.
  - In cycle t+1 after an issue: out_data<=ch_data[rd_ch*DW +: DW], out_ch<=rd_ch, out_valid<=1, rd_pend<=0.
- Throughput: back-to-back issues on one channel are legal (1 word/cycle), because buf_empty updates on the same clk_rd edge as the FIFO counter.
- Output handshake:
  - When out_valid & out_ready: word_count++ (mod 2^16).
  - out_valid clears unless a new word lands in the same cycle.
  - out_data/out_ch are held stable while out_valid & !out_ready.
- Channel disabled mid-burst: no further reads from it; a read already in flight is still delivered.
- ch_empty must already be in the clk_rd domain; the write-side full flag is not used.
- Single-channel case: that channel re-wins after every burst, with a 1-cycle IDLE gap.

Test Plan:
- Ch1 holds 3 words (0x11,0x22,0x33), others empty, out_ready=1:
  - rd_en[1] pulses 3 consecutive cycles starting 1 cycle after empty drops.
  - out_ch=1 with data 0x11,0x22,0x33 on consecutive cycles; word_count=3; back to IDLE with rr_ptr=2.
- Ch0 and ch2 each hold 6 words, BURST_MAX=4:
  - Delivery order is ch0 x4, ch2 x4, ch0 x2, ch2 x2.
  - Each burst is separated by exactly one idle cycle; word_count=12.
- Backpressure: out_ready=0 for 5 cycles mid-burst:
  - At most 1 word is held; out_data stable; no rd_en while blocked.
  - Resumes with no lost or duplicated byte (compare against scoreboard).
- ch_enable=4'b1011 with all channels non-empty:
  - ch2 is never granted; grant order 0,1,3,0, with rr_ptr wrapping 3->0.
- rst asserted during a burst (rd_en high):
  - Outputs zero immediately; after release the first grant goes to ch0 (rr_ptr=0); word_count=0.
- 65536 handshakes: word_count wraps to 0 exactly on the 65536th accept.

Source files
------------

// File: rtl/fifo_rd_scheduler.sv
// fifo_rd_scheduler
//   Read-side scheduler for N_CH dual-clock FIFOs, entirely in the clk_rd
//   domain. Channels are granted round-robin, each grant allows up to
//   BURST_MAX reads, and the words are merged into one valid/ready stream
//   tagged with the source channel.
//
// Ports
//   clk_rd      read-domain clock shared with all FIFO read sides
//   rst         asynchronous, active-high reset
//   ch_empty    per-FIFO buf_empty (bit i = channel i, clk_rd domain)
//   ch_data     per-FIFO registered buf_out, channel i at [i*DW +: DW]
//   ch_enable   channel mask, 0 = never granted
//   ch_rd_en    per-FIFO rd_en, one-hot or zero
//   out_data    output word
//   out_ch      source channel of out_data
//   out_valid   output word valid
//   out_ready   downstream accepts when out_valid & out_ready
//   busy        burst in progress or a read in flight
//   word_count  accepted words, wraps modulo 2^16
module fifo_rd_scheduler #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned CHW       = 2
) (
  input  logic             clk_rd,
  input  logic             rst,
  input  logic [N_CH-1:0]  ch_empty,
  input  logic [N_CH*DW-1:0] ch_data,
  input  logic [N_CH-1:0]  ch_enable,
  output logic [N_CH-1:0]  ch_rd_en,
  output logic [DW-1:0]    out_data,
  output logic [CHW-1:0]   out_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [15:0]      word_count
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [CHW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CHW-1:0]  grant_q, grant_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic            rd_pend_q;
  logic [CHW-1:0]  rd_ch_q;
  logic [DW-1:0]   out_data_q;
  logic [CHW-1:0]  out_ch_q;
  logic            out_valid_q;
  logic [15:0]     word_count_q;

  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] rd_en;
  logic [CHW-1:0]  pick;
  logic [CHW-1:0]  cand_c;
  int unsigned     cand;
  logic [CHW-1:0]  grant_nxt;
  logic            found;
  logic            can_issue;
  logic            issue;
  logic            capture;
  logic            accept;
  logic            last_beat;
  logic [DW-1:0]   ch_word [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign ch_word[gi] = ch_data[gi*DW +: DW];
  end

  assign eligible  = ch_enable & ~ch_empty;
  assign accept    = out_valid_q & out_ready;
  assign can_issue = (!out_valid_q | out_ready) & !(rd_pend_q & out_valid_q & !out_ready);
  // A pending read whose word cannot land yet stays pending: the FIFO's
  // buf_out register holds that word until its next rd_en, and no rd_en is
  // issued while the output slot is blocked, so it is captured once free.
  assign capture   = rd_pend_q & (!out_valid_q | out_ready);
  assign grant_nxt = (grant_q == CHW'(N_CH - 1)) ? '0 : grant_q + CHW'(1);
  assign last_beat = (burst_cnt_q == 4'(BURST_MAX - 1));

  // First eligible channel searching from rr_ptr upwards, modulo N_CH.
  always_comb begin
    found  = 1'b0;
    pick   = rr_ptr_q;
    cand   = 0;
    cand_c = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand   = (32'(rr_ptr_q) + k) % N_CH;
      cand_c = CHW'(cand);
      if (!found && eligible[cand_c]) begin
        found = 1'b1;
        pick  = cand_c;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    rd_en       = '0;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d     = pick;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (can_issue) begin
          if (ch_empty[grant_q] || !ch_enable[grant_q]) begin
            state_d  = IDLE;
            rr_ptr_d = grant_nxt;
          end else begin
            issue          = 1'b1;
            rd_en[grant_q] = 1'b1;
            burst_cnt_d    = burst_cnt_q + 4'd1;
            if (last_beat) begin
              state_d  = IDLE;
              rr_ptr_d = grant_nxt;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      rd_pend_q    <= 1'b0;
      rd_ch_q      <= '0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      rd_pend_q <= issue | (rd_pend_q & !capture);
      if (issue) begin
        rd_ch_q <= grant_q;
      end
      if (capture) begin
        out_data_q  <= ch_word[rd_ch_q];
        out_ch_q    <= rd_ch_q;
        out_valid_q <= 1'b1;
      end else if (accept) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        word_count_q <= word_count_q + 16'd1;
      end
    end
  end

  assign ch_rd_en   = rd_en;
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q == BURST) | rd_pend_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// tb_fifo_rd_scheduler
//   Drives fifo_rd_scheduler from four modelled FIFOs (registered buf_out,
//   empty updated on the read edge) and checks the merged stream against an
//   expected word list built from the arbitration rules. A second instance
//   with a long burst length is kept permanently busy to reach the 16-bit
//   word counter wrap.
module tb_fifo_rd_scheduler;

  localparam int unsigned NCH  = 4;
  localparam int unsigned BMAX = 4;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } item_t;

  logic        clk_rd = 1'b0;
  logic        rst;
  logic [3:0]  ch_empty;
  logic [31:0] ch_data;
  logic [3:0]  ch_enable;
  logic [3:0]  ch_rd_en;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [15:0] word_count;

  logic        w_rst;
  logic [3:0]  w_empty  = 4'b0000;
  logic [31:0] w_din    = 32'h4433_2211;
  logic [3:0]  w_enable = 4'b1111;
  logic        w_ready  = 1'b1;
  logic [3:0]  w_rd_en;
  logic [7:0]  w_data;
  logic [1:0]  w_ch;
  logic        w_valid;
  logic        w_busy;
  logic [15:0] w_count;

  always #5 clk_rd = ~clk_rd;

  fifo_rd_scheduler #(.N_CH(4), .DW(8), .BURST_MAX(BMAX), .CHW(2)) u_dut (
    .clk_rd(clk_rd), .rst(rst), .ch_empty(ch_empty), .ch_data(ch_data),
    .ch_enable(ch_enable), .ch_rd_en(ch_rd_en), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .word_count(word_count)
  );

  fifo_rd_scheduler #(.N_CH(4), .DW(8), .BURST_MAX(15), .CHW(2)) u_wrap (
    .clk_rd(clk_rd), .rst(w_rst), .ch_empty(w_empty), .ch_data(w_din),
    .ch_enable(w_enable), .ch_rd_en(w_rd_en), .out_data(w_data),
    .out_ch(w_ch), .out_valid(w_valid), .out_ready(w_ready),
    .busy(w_busy), .word_count(w_count)
  );

  // FIFO models: ring of 64 bytes per channel, head advanced by rd_en.
  logic [7:0]  fmem [4][64];
  int unsigned head [4];
  int unsigned tail [4];
  bit   [7:0]  buf_out [4];

  always @(posedge clk_rd) begin
    for (int c = 0; c < 4; c++) begin
      if (ch_rd_en[c] && head[c] != tail[c]) begin
        buf_out[c] <= fmem[c][head[c] % 64];
        head[c]    <= head[c] + 1;
      end
    end
  end

  always_comb begin
    ch_data  = '0;
    ch_empty = '0;
    for (int c = 0; c < 4; c++) begin
      ch_data[c*8 +: 8] = buf_out[c];
      ch_empty[c]       = (head[c] == tail[c]);
    end
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  item_t       exp_q[$];
  logic [15:0] wc_model = '0;
  int unsigned rr_model = 0;
  bit          mon_en = 1'b0;
  bit          hold = 1'b0;
  logic [7:0]  hold_data;
  logic [1:0]  hold_ch;

  int unsigned wacc = 0;
  bit          w_pend = 1'b0;
  logic [15:0] w_exp;
  bit          wrap_done = 1'b0;

  // Stream monitor, sampled mid-cycle.
  always @(negedge clk_rd) begin
    item_t it;
    if (!rst && mon_en) begin
      if (ch_rd_en != '0) begin
        chk("rd_onehot", 32'($countones(ch_rd_en)), 32'd1);
        for (int c = 0; c < 4; c++) begin
          if (ch_rd_en[c]) begin
            chk("rd_nonempty", 32'(ch_empty[c]), 32'd0);
            chk("rd_enabled", 32'(ch_enable[c]), 32'd1);
          end
        end
        chk("rd_while_blocked", 32'(out_valid & !out_ready), 32'd0);
      end
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(hold_data));
        chk("hold_ch", 32'(out_ch), 32'(hold_ch));
      end
      if (out_valid && out_ready) begin
        chk("word_count", 32'(word_count), 32'(wc_model));
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          it = exp_q.pop_front();
          chk("out_ch", 32'(out_ch), 32'(it.ch));
          chk("out_data", 32'(out_data), 32'(it.data));
        end
        wc_model = wc_model + 16'd1;
      end
      hold      = out_valid & !out_ready;
      hold_data = out_data;
      hold_ch   = out_ch;
    end else begin
      hold = 1'b0;
    end

    if (!w_rst) begin
      if (w_pend) begin
        chk("wrap_count", 32'(w_count), 32'(w_exp));
        w_pend = 1'b0;
        if (w_exp == 16'd0) wrap_done = 1'b1;
      end
      if (w_valid && w_ready) begin
        wacc++;
        if (wacc == 65535 || wacc == 65536) begin
          w_pend = 1'b1;
          w_exp  = 16'(wacc);
        end
      end
    end
  end

  logic [7:0]  ld [4][16];
  int unsigned ln [4];

  task automatic tick();
    @(posedge clk_rd);
    #2;
  endtask

  // Push ln/ld into the FIFOs in one step and append the expected delivery
  // order: repeatedly grant the next enabled non-empty channel from the
  // round-robin pointer, take up to BMAX words, move the pointer past it.
  task automatic load_run();
    int unsigned rem [4];
    int unsigned pos [4];
    int          g;
    item_t       it;
    for (int c = 0; c < 4; c++) begin
      for (int unsigned i = 0; i < ln[c]; i++) fmem[c][(tail[c] + i) % 64] = ld[c][i];
      rem[c] = ln[c];
      pos[c] = 0;
    end
    for (int c = 0; c < 4; c++) tail[c] = tail[c] + ln[c];
    forever begin
      g = -1;
      for (int unsigned k = 0; k < NCH; k++) begin
        int unsigned cc;
        cc = (rr_model + k) % NCH;
        if (g < 0 && ch_enable[cc] && rem[cc] > 0) g = int'(cc);
      end
      if (g < 0) break;
      for (int unsigned b = 0; b < BMAX && rem[g] > 0; b++) begin
        it.ch   = 2'(g);
        it.data = ld[g][pos[g]];
        exp_q.push_back(it);
        pos[g]++;
        rem[g]--;
      end
      rr_model = (int'(g) + 1) % NCH;
    end
    for (int c = 0; c < 4; c++) ln[c] = 0;
  endtask

  task automatic rand_fill(input int c, input int unsigned n);
    ln[c] = n;
    for (int unsigned i = 0; i < n; i++) ld[c][i] = 8'($urandom_range(0, 255));
  endtask

  task automatic clear_fifos();
    for (int c = 0; c < 4; c++) tail[c] = head[c];
  endtask

  task automatic wait_drain(input bit rnd);
    int unsigned n;
    n = 0;
    while (n < 3000 && !(exp_q.size() == 0 && !busy && !out_valid && ch_rd_en == '0)) begin
      tick();
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    out_ready = 1'b1;
    if (n >= 3000) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    logic       t1_rd [6];
    logic [7:0] t1_d [3];
    logic [15:0] wc_before;
    int unsigned n;
    t1_rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    t1_d  = '{8'h11, 8'h22, 8'h33};
    for (int c = 0; c < 4; c++) ln[c] = 0;

    rst       = 1'b1;
    w_rst     = 1'b1;
    out_ready = 1'b1;
    ch_enable = '0;
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_rd_en", 32'(ch_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst    = 1'b0;
    w_rst  = 1'b0;
    mon_en = 1'b1;
    tick();

    // Three words on channel 1: one arbitration cycle, then three reads.
    ch_enable = 4'b1111;
    ln[1] = 3;
    for (int i = 0; i < 3; i++) ld[1][i] = t1_d[i];
    load_run();
    @(negedge clk_rd);
    chk("t1_arb_gap", 32'(ch_rd_en), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_rd);
      chk("t1_rd_en", 32'(ch_rd_en[1]), 32'(t1_rd[k]));
      chk("t1_valid", 32'(out_valid), 32'(k >= 2 && k <= 4));
      if (k >= 2 && k <= 4) begin
        chk("t1_data", 32'(out_data), 32'(t1_d[k-2]));
        chk("t1_ch", 32'(out_ch), 32'd1);
      end
    end
    chk("t1_wc", 32'(word_count), 32'd3);
    chk("t1_busy", 32'(busy), 32'd0);
    tick();
    wait_drain(1'b0);
    clear_fifos();

    // Two deep channels alternate in bursts of BMAX.
    wc_before = wc_model;
    rand_fill(0, 6);
    rand_fill(2, 6);
    load_run();
    wait_drain(1'b0);
    chk("t2_wc", 32'(word_count), 32'(wc_before + 16'd12));
    clear_fifos();

    // Downstream stall for five cycles in the middle of a burst.
    rand_fill(3, 8);
    load_run();
    repeat (3) tick();
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    wait_drain(1'b0);
    clear_fifos();

    // Channel 2 masked off while holding data.
    ch_enable = 4'b1011;
    rand_fill(0, 6);
    rand_fill(1, 2);
    rand_fill(2, 3);
    rand_fill(3, 2);
    load_run();
    wait_drain(1'b0);
    chk("t4_ch2_left", tail[2] - head[2], 32'd3);
    clear_fifos();

    // Random depths, masks and downstream backpressure.
    for (int it = 0; it < 40; it++) begin
      ch_enable = 4'($urandom_range(0, 15));
      for (int c = 0; c < 4; c++) rand_fill(c, $urandom_range(0, 9));
      load_run();
      wait_drain(1'b1);
      clear_fifos();
    end

    // Reset while a read is being issued.
    ch_enable = 4'b1111;
    rand_fill(2, 8);
    load_run();
    n = 0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk_rd);
      if (ch_rd_en != '0) break;
    end
    chk("t6_burst_seen", 32'(ch_rd_en != '0), 32'd1);
    #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("t6_rd_en", 32'(ch_rd_en), 32'd0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_data", 32'(out_data), 32'd0);
    chk("t6_ch", 32'(out_ch), 32'd0);
    chk("t6_wc", 32'(word_count), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    exp_q.delete();
    wc_model = '0;
    rr_model = 0;
    repeat (2) tick();
    clear_fifos();
    rst    = 1'b0;
    mon_en = 1'b1;
    chk("t6_wc_after", 32'(word_count), 32'd0);
    rand_fill(0, 2);
    rand_fill(3, 2);
    load_run();
    for (n = 0; n < 20; n++) begin
      @(negedge clk_rd);
      if (out_valid) break;
    end
    chk("t6_first_ch", 32'(out_ch), 32'd0);
    tick();
    wait_drain(1'b0);
    clear_fifos();

    // Let the always-busy instance reach its counter wrap.
    for (n = 0; n < 80000 && !wrap_done; n++) tick();
    if (!wrap_done) chk("wrap_timeout", 32'(wacc), 32'd65536);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
